// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment codes and
// active-low polarity levels.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic       AN_ON   = 1'b0;
    localparam logic       AN_OFF  = 1'b1;
    localparam logic       DP_ON   = 1'b0;
    localparam logic       DP_OFF  = 1'b1;

    // Entry n is the active-low pattern {g,f,e,d,c,b,a} for hex digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/seg_scan_driver_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector; rise is high for
// one CLK cycle per rising edge of the asynchronous input d.
module edge_sync (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic rise
);

    logic s1_q, s2_q, prev_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= d;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with per-frame value snapshot.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        TICK_IN,
    input  logic [4*DIGITS-1:0]         VALUE,
    input  logic [DIGITS-1:0]           DP_IN,
    output logic [DIGITS-1:0]           AN,
    output logic [6:0]                  SEG,
    output logic                        DP,
    output logic [$clog2(DIGITS)-1:0]   SCAN_IDX
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic                  tick;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   snap_val_q;
    logic [DIGITS-1:0]     snap_dp_q;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  wrap;
    logic [4*DIGITS-1:0]   cur_val;
    logic [DIGITS-1:0]     cur_dp;
    logic [3:0]            nib;
    logic                  dp_bit;
    logic                  blank;

    edge_sync u_tick_sync (
        .CLK  (CLK),
        .RST  (RST),
        .d    (TICK_IN),
        .rise (tick)
    );

    // On the wrap tick digit 0 is decoded from the live inputs, so the new
    // frame starts from the same data the snapshot is about to capture.
    assign wrap    = (idx_q == LAST_IDX);
    assign idx_d   = wrap ? '0 : idx_q + IDX_W'(1);
    assign cur_val = wrap ? VALUE : snap_val_q;
    assign cur_dp  = wrap ? DP_IN : snap_dp_q;
    assign nib     = cur_val[{idx_d, 2'b00} +: 4];
    assign dp_bit  = cur_dp[idx_d];

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic upper_zero;

    always_comb begin
        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(idx_d) && cur_val[4*j +: 4] != 4'h0)
                upper_zero = 1'b0;
        end
        blank = (idx_d != '0) && upper_zero && !dp_bit;
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        an_d = {DIGITS{AN_OFF}};
        if (!blank)
            an_d[idx_d] = AN_ON;
        seg_d = blank ? SEG_OFF : hex_to_seg(nib);
        dp_d  = (blank || !dp_bit) ? DP_OFF : DP_ON;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            idx_q      <= LAST_IDX;
            snap_val_q <= '0;
            snap_dp_q  <= '0;
            an_q       <= {DIGITS{AN_OFF}};
            seg_q      <= SEG_OFF;
            dp_q       <= DP_OFF;
        end else if (tick) begin
            idx_q <= idx_d;
            if (wrap) begin
                snap_val_q <= VALUE;
                snap_dp_q  <= DP_IN;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign AN       = an_q;
    assign SEG      = seg_q;
    assign DP       = dp_q;
    assign SCAN_IDX = idx_q;

endmodule
